// File: rtl/alsu_pkg.sv
// Shared types and constants for the registered arithmetic/logic/shift unit.
package alsu_pkg;

  localparam int OUT_W = 6;
  localparam int LED_W = 16;
  localparam int IN_W  = 3;

  typedef enum logic [2:0] {
    OR_AND    = 3'b000,
    OP_XOR    = 3'b001,
    OP_ADD    = 3'b010,
    OP_MUL    = 3'b011,
    OP_SHIFT  = 3'b100,
    OP_ROTATE = 3'b101,
    OP_INV6   = 3'b110,
    OP_INV7   = 3'b111
  } opcode_e;

  // One captured set of controller inputs (stage-1 contents).
  typedef struct packed {
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic            cin;
    logic            serial_in;
    logic            red_op_a;
    logic            red_op_b;
    opcode_e         opcode;
    logic            bypass_a;
    logic            bypass_b;
    logic            direction;
  } alsu_in_t;

  // Sign-extend a 3-bit operand to the result width.
  function automatic logic [OUT_W-1:0] sext_in(input logic [IN_W-1:0] v);
    return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alsu_in_reg.sv
// Stage-1 input register bank: captures every controller input each clock.
module alsu_in_reg
  import alsu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  alsu_in_t d_i,
  output alsu_in_t q_o
);

  alsu_in_t in_q;

  // Capture all inputs every clock; synchronous reset clears the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
    end else begin
      in_q <= d_i;
    end
  end

  assign q_o = in_q;

endmodule

// File: rtl/alsu_core.sv
// Registered ALU/shift unit: inputs registered in stage 1, result and
// illegal-operation LED blink registered in stage 2 (two-clock latency).
module alsu_core
  import alsu_pkg::*;
#(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic [2:0]       opcode,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic             direction,
  output logic [LED_W-1:0] leds,
  output logic [OUT_W-1:0] out
);

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  alsu_in_t         in_s;
  alsu_in_t         r_q;
  logic             invalid_s;
  logic [OUT_W-1:0] a_ext_s;
  logic [OUT_W-1:0] b_ext_s;
  logic [IN_W-1:0]  red_src_s;
  logic             use_red_s;
  logic [OUT_W-1:0] and_s;
  logic [OUT_W-1:0] xor_s;
  logic [OUT_W-1:0] add_s;
  logic [OUT_W-1:0] mul_s;
  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;
  logic [LED_W-1:0] leds_d;
  logic [LED_W-1:0] leds_q;

  assign in_s.a         = A;
  assign in_s.b         = B;
  assign in_s.cin       = cin;
  assign in_s.serial_in = serial_in;
  assign in_s.red_op_a  = red_op_A;
  assign in_s.red_op_b  = red_op_B;
  assign in_s.opcode    = opcode_e'(opcode);
  assign in_s.bypass_a  = bypass_A;
  assign in_s.bypass_b  = bypass_B;
  assign in_s.direction = direction;

  alsu_in_reg u_in_reg (
    .clk (clk),
    .rst (rst),
    .d_i (in_s),
    .q_o (r_q)
  );

  assign a_ext_s = sext_in(r_q.a);
  assign b_ext_s = sext_in(r_q.b);

  // Illegal: reserved opcodes, or a reduction flag on a non-AND/XOR opcode.
  always_comb begin
    invalid_s = 1'b0;
    case (r_q.opcode)
      OP_INV6, OP_INV7: invalid_s = 1'b1;
      OR_AND, OP_XOR:   invalid_s = 1'b0;
      default:          invalid_s = r_q.red_op_a | r_q.red_op_b;
    endcase
  end

  // Pick the reduction operand; with both flags set the priority operand wins.
  always_comb begin
    red_src_s = r_q.b;
    use_red_s = r_q.red_op_a | r_q.red_op_b;
    if (r_q.red_op_a && r_q.red_op_b) begin
      red_src_s = PRIO_A ? r_q.a : r_q.b;
    end else if (r_q.red_op_a) begin
      red_src_s = r_q.a;
    end else begin
      red_src_s = r_q.b;
    end
  end

  // Logic and arithmetic results; reductions are zero-extended, the rest signed.
  always_comb begin
    if (use_red_s) begin
      and_s = {5'b00000, &red_src_s};
      xor_s = {5'b00000, ^red_src_s};
    end else begin
      and_s = a_ext_s & b_ext_s;
      xor_s = a_ext_s ^ b_ext_s;
    end
    add_s = a_ext_s + b_ext_s + {5'b00000, (r_q.cin & USE_CIN)};
    mul_s = $signed(a_ext_s) * $signed(b_ext_s);
  end

  // Result select: bypass, then invalid, then opcode decode.
  always_comb begin
    out_d = out_q;
    if (r_q.bypass_a && r_q.bypass_b) begin
      out_d = PRIO_A ? a_ext_s : b_ext_s;
    end else if (r_q.bypass_a) begin
      out_d = a_ext_s;
    end else if (r_q.bypass_b) begin
      out_d = b_ext_s;
    end else if (invalid_s) begin
      out_d = 6'b000000;
    end else begin
      case (r_q.opcode)
        OR_AND:   out_d = and_s;
        OP_XOR:   out_d = xor_s;
        OP_ADD:   out_d = add_s;
        OP_MUL:   out_d = mul_s;
        OP_SHIFT: out_d = r_q.direction ? {out_q[4:0], r_q.serial_in}
                                        : {r_q.serial_in, out_q[5:1]};
        OP_ROTATE: out_d = r_q.direction ? {out_q[4:0], out_q[5]}
                                         : {out_q[0], out_q[5:1]};
        default:  out_d = 6'b000000;
      endcase
    end
  end

  // LEDs blink while the registered operation is illegal, dark otherwise.
  always_comb begin
    if (invalid_s) begin
      leds_d = ~leds_q;
    end else begin
      leds_d = 16'h0000;
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= 6'b000000;
      leds_q <= 16'h0000;
    end else begin
      out_q  <= out_d;
      leds_q <= leds_d;
    end
  end

  assign out  = out_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_alsu_core.sv
// Self-checking bench for alsu_core: directed literal cases plus random
// stimulus checked every clock against a behavioural model.
module tb_alsu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [15:0] leds;
  logic [5:0]  out;

  int vectors = 0;
  int miscompares = 0;

  alsu_core #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .opcode(opcode),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
    .leds(leds), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a, b, op;
    logic cin, sin, ra, rb, ba, bb, dir;
  } vec_t;

  vec_t        stg;
  logic [5:0]  m_out;
  logic [15:0] m_leds;

  function automatic bit is_invalid(vec_t v);
    return (v.op >= 3'd6) || ((v.ra || v.rb) && (v.op > 3'd1));
  endfunction

  function automatic int red_val(vec_t v, bit use_xor);
    logic [2:0] x;
    if (v.ra && v.rb) x = v.a;      // A has priority
    else if (v.ra)    x = v.a;
    else              x = v.b;
    if (use_xor) return $countones(x) % 2;
    return (x == 3'b111) ? 1 : 0;
  endfunction

  function automatic logic [5:0] model_out(vec_t v, logic [5:0] prev);
    int a, b, p, r;
    a = $signed(v.a);
    b = $signed(v.b);
    p = int'(prev);
    if (v.ba)                 r = a;   // A wins when both bypass flags set
    else if (v.bb)            r = b;
    else if (is_invalid(v))   r = 0;
    else begin
      case (v.op)
        3'd0: r = (v.ra || v.rb) ? red_val(v, 1'b0) : (a & b);
        3'd1: r = (v.ra || v.rb) ? red_val(v, 1'b1) : (a ^ b);
        3'd2: r = a + b + int'(v.cin);
        3'd3: r = a * b;
        3'd4: r = v.dir ? ((p * 2) % 64 + int'(v.sin)) : (p / 2 + 32 * int'(v.sin));
        3'd5: r = v.dir ? ((p * 2) % 64 + p / 32) : (p / 2 + 32 * (p % 2));
        default: r = 0;
      endcase
    end
    return 6'(r);
  endfunction

  task automatic check6(string name, logic [5:0] got, logic [5:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: out=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check16(string name, logic [15:0] got, logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: leds=%h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update and per-cycle compare, 1 time unit after each rising edge.
  initial begin
    vec_t cur;
    forever begin
      @(posedge clk);
      cur = '{a: A, b: B, op: opcode, cin: cin, sin: serial_in, ra: red_op_A,
              rb: red_op_B, ba: bypass_A, bb: bypass_B, dir: direction};
      if (rst) begin
        stg    = '{default: '0};
        m_out  = 6'h00;
        m_leds = 16'h0000;
      end else begin
        m_leds = is_invalid(stg) ? ~m_leds : 16'h0000;
        m_out  = model_out(stg, m_out);
        stg    = cur;
      end
      #1;
      check6("model_out", out, m_out);
      check16("model_leds", leds, m_leds);
    end
  end

  task automatic clear_inputs();
    A = 3'b000; B = 3'b000; opcode = 3'b000; cin = 1'b0; serial_in = 1'b0;
    red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
    direction = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed literal cases, then random stimulus.
  initial begin
    logic [15:0] l0;
    rst = 1'b1;
    clear_inputs();
    step(1);
    check6("reset_out", out, 6'b000000);
    check16("reset_leds", leds, 16'h0000);
    rst = 1'b0;
    step(2);
    check6("idle_out", out, 6'b000000);
    check16("idle_leds", leds, 16'h0000);

    opcode = 3'b010; A = 3'b011; B = 3'b010; cin = 1'b1;
    step(2); check6("add_3_2_c", out, 6'b000110);
    opcode = 3'b011; A = 3'b100; B = 3'b100; cin = 1'b0;
    step(2); check6("mul_m4_m4", out, 6'b010000);
    A = 3'b011; B = 3'b110;
    step(2); check6("mul_3_m2", out, 6'b111010);
    opcode = 3'b000; red_op_A = 1'b1; red_op_B = 1'b1; A = 3'b111; B = 3'b011;
    step(2); check6("red_and_prio", out, 6'b000001);
    opcode = 3'b001; red_op_A = 1'b0; red_op_B = 1'b1; B = 3'b011;
    step(2); check6("red_xor_b", out, 6'b000000);

    opcode = 3'b110; red_op_B = 1'b0;
    step(2); check6("inv_out", out, 6'b000000); check16("inv_blink0", leds, 16'hFFFF);
    step(1); check16("inv_blink1", leds, 16'h0000);
    step(1); check16("inv_blink2", leds, 16'hFFFF);
    opcode = 3'b000;
    step(2); check16("valid_dark", leds, 16'h0000);

    opcode = 3'b010; red_op_A = 1'b1;
    step(2); check6("inv_red_out", out, 6'b000000); check16("inv_red_leds", leds, 16'hFFFF);

    red_op_A = 1'b0; bypass_A = 1'b1; bypass_B = 1'b1; A = 3'b111; B = 3'b010; opcode = 3'b111;
    step(2); check6("bypass_both", out, 6'b111111);
    l0 = leds;
    step(1); check6("bypass_hold", out, 6'b111111); check16("bypass_blink", leds, ~l0);

    bypass_A = 1'b0; bypass_B = 1'b0; opcode = 3'b010; A = 3'b011; B = 3'b010; cin = 1'b1;
    step(2); check6("preload", out, 6'b000110); check16("preload_leds", leds, 16'h0000);
    opcode = 3'b100; direction = 1'b1; serial_in = 1'b1;
    step(1);
    opcode = 3'b101; direction = 1'b0;
    step(1); check6("shift_left", out, 6'b001101);
    step(1); check6("rotate_right", out, 6'b100110);

    repeat (800) begin
      rst       = ($urandom_range(0, 39) == 0);
      A         = 3'($urandom_range(0, 7));
      B         = 3'($urandom_range(0, 7));
      opcode    = 3'($urandom_range(0, 7));
      cin       = 1'($urandom_range(0, 1));
      serial_in = 1'($urandom_range(0, 1));
      direction = 1'($urandom_range(0, 1));
      red_op_A  = ($urandom_range(0, 5) == 0);
      red_op_B  = ($urandom_range(0, 5) == 0);
      bypass_A  = ($urandom_range(0, 7) == 0);
      bypass_B  = ($urandom_range(0, 7) == 0);
      step(1);
    end
    rst = 1'b0;
    clear_inputs();
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
